// File: rtl/axi_sram_ctrl_if.sv
// AXI4-Lite bus between picorv32_axi (master) and the SRAM controller (slave).
interface axi_sram_ctrl_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi_sram_ctrl.sv
// AXI4-Lite slave sharing one single-port SRAM between read and write channels,
// with round-robin arbitration, a byte-wide MMIO output and an out-of-bounds flag.
module axi_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [31:0] MMIO_ADDR  = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  axi_sram_ctrl_if.slave        mem_axi,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-3:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  err,
  output logic [31:0]           err_addr
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAPT, RD_RESP, WR_ISSUE, WR_RESP
  } state_t;

  state_t      state;
  logic        rdy_en;     // keeps the ready lines low while in reset
  logic        aw_held, w_held, ar_held;
  logic        prio_wr;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [3:0]  w_strb_q;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        rvalid_q, bvalid_q;
  logic [31:0] rdata_q;

  logic aw_hs, w_hs, ar_hs, wr_pend, rd_pend;
  logic in_range, is_mmio, rd_ok, wr_sram, wr_oob;
  logic rd_go, wr_go, mmio_go;
  logic unused_prot;

  assign unused_prot = ^{mem_axi.awprot, mem_axi.arprot};

  assign mem_axi.awready = rdy_en & ~aw_held;
  assign mem_axi.wready  = rdy_en & ~w_held;
  assign mem_axi.arready = rdy_en & ~ar_held;
  assign mem_axi.bvalid  = bvalid_q;
  assign mem_axi.rvalid  = rvalid_q;
  assign mem_axi.rdata   = rdata_q;

  assign aw_hs   = mem_axi.awvalid & mem_axi.awready;
  assign w_hs    = mem_axi.wvalid  & mem_axi.wready;
  assign ar_hs   = mem_axi.arvalid & mem_axi.arready;
  assign wr_pend = aw_held & w_held;
  assign rd_pend = ar_held;

  // Address classification of the transaction currently in service.
  assign in_range = (cur_addr >> ADDR_WIDTH) == 32'd0;
  assign is_mmio  = cur_addr == MMIO_ADDR;
  assign rd_ok    = in_range & ~is_mmio;
  assign wr_sram  = in_range & ~is_mmio;
  assign wr_oob   = ~in_range & ~is_mmio;

  assign rd_go   = (state == RD_ISSUE) & rd_ok;
  assign wr_go   = (state == WR_ISSUE) & wr_sram;
  assign mmio_go = (state == WR_ISSUE) & is_mmio;

  // SRAM strobes and MMIO pulse decoded from the ISSUE states only.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'd0;
    sram_addr  = '0;
    sram_wdata = 32'd0;
    out_valid  = 1'b0;
    out_data   = 8'd0;
    if (rd_go || wr_go) begin
      sram_en   = 1'b1;
      sram_addr = cur_addr[ADDR_WIDTH-1:2];
    end
    if (wr_go) begin
      sram_we    = cur_wstrb;
      sram_wdata = cur_wdata;
    end
    if (mmio_go) begin
      out_valid = 1'b1;
      out_data  = cur_wdata[7:0];
    end
  end

  // Channel holding registers, arbitration and service FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      ar_held   <= 1'b0;
      prio_wr   <= 1'b1;
      aw_addr_q <= 32'd0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      ar_addr_q <= 32'd0;
      cur_addr  <= 32'd0;
      cur_wdata <= 32'd0;
      cur_wstrb <= 4'd0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      err       <= 1'b0;
      err_addr  <= 32'd0;
    end else begin
      rdy_en <= 1'b1;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= mem_axi.awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= mem_axi.wdata;
        w_strb_q <= mem_axi.wstrb;
      end
      if (ar_hs) begin
        ar_held   <= 1'b1;
        ar_addr_q <= mem_axi.araddr;
      end
      case (state)
        IDLE: begin
          if (wr_pend && (!rd_pend || prio_wr)) begin
            cur_addr  <= aw_addr_q;
            cur_wdata <= w_data_q;
            cur_wstrb <= w_strb_q;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            prio_wr   <= 1'b0;
            state     <= WR_ISSUE;
          end else if (rd_pend) begin
            cur_addr <= ar_addr_q;
            ar_held  <= 1'b0;
            prio_wr  <= 1'b1;
            state    <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (!rd_ok) begin
            err <= 1'b1;
            if (!err) err_addr <= cur_addr;
          end
          state <= RD_CAPT;
        end
        RD_CAPT: begin
          rdata_q  <= rd_ok ? sram_rdata : 32'd0;
          rvalid_q <= 1'b1;
          state    <= RD_RESP;
        end
        RD_RESP: begin
          if (mem_axi.rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        WR_ISSUE: begin
          if (wr_oob) begin
            err <= 1'b1;
            if (!err) err_addr <= cur_addr;
          end
          bvalid_q <= 1'b1;
          state    <= WR_RESP;
        end
        WR_RESP: begin
          if (mem_axi.bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_ctrl.sv
// Directed bench for axi_sram_ctrl with a behavioural SRAM and a response-order log.
module tb_axi_sram_ctrl;
  localparam int unsigned AW     = 16;
  localparam int unsigned BUDGET = 60;

  logic          clk;
  logic          resetn;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-3:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          err;
  logic [31:0]   err_addr;

  axi_sram_ctrl_if mem_axi();

  axi_sram_ctrl #(.ADDR_WIDTH(AW), .MMIO_ADDR(32'h1000_0000)) dut (
    .clk(clk), .resetn(resetn), .mem_axi(mem_axi),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_data(out_data),
    .err(err), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:(1<<(AW-2))-1];
  int          n_en;
  int          n_out;
  logic [7:0]  out_byte;
  int          evt[$];
  logic [31:0] rlog[$];

  // Behavioural SRAM plus activity and response-order monitors.
  always @(posedge clk) begin
    if (sram_en) begin
      n_en <= n_en + 1;
      if (sram_we == 4'd0) sram_rdata <= mem[sram_addr];
      else for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    if (out_valid) begin
      n_out    <= n_out + 1;
      out_byte <= out_data;
    end
    if (resetn && mem_axi.bvalid && mem_axi.bready) evt.push_back(0);
    if (resetn && mem_axi.rvalid && mem_axi.rready) begin
      evt.push_back(1);
      rlog.push_back(mem_axi.rdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_ok, w_ok, ha, hw;
    int n;
    aw_ok = 0; w_ok = 0; n = 0;
    mem_axi.awaddr = a; mem_axi.wdata = d; mem_axi.wstrb = s;
    mem_axi.awvalid = 1'b1; mem_axi.wvalid = 1'b1;
    while (!(aw_ok && w_ok) && n < BUDGET) begin
      ha = mem_axi.awvalid && mem_axi.awready;
      hw = mem_axi.wvalid && mem_axi.wready;
      tick(); n++;
      if (ha) begin aw_ok = 1; mem_axi.awvalid = 1'b0; end
      if (hw) begin w_ok = 1; mem_axi.wvalid = 1'b0; end
    end
    mem_axi.awvalid = 1'b0; mem_axi.wvalid = 1'b0;
    chk("w_handshake", {62'd0, aw_ok, w_ok}, 64'd3);
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit ok, h;
    int n;
    ok = 0; n = 0;
    mem_axi.araddr = a; mem_axi.arvalid = 1'b1;
    while (!ok && n < BUDGET) begin
      h = mem_axi.arvalid && mem_axi.arready;
      tick(); n++;
      if (h) ok = 1;
    end
    mem_axi.arvalid = 1'b0;
    chk("ar_handshake", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (!mem_axi.bvalid && lat < BUDGET) begin tick(); lat++; end
    chk("b_seen", {63'd0, mem_axi.bvalid}, 64'd1);
  endtask

  task automatic wait_r(output int lat, output logic [31:0] d);
    lat = 0;
    while (!mem_axi.rvalid && lat < BUDGET) begin tick(); lat++; end
    chk("r_seen", {63'd0, mem_axi.rvalid}, 64'd1);
    d = mem_axi.rdata;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {61'd0, mem_axi.awready, mem_axi.wready, mem_axi.arready}, 64'd0);
    chk({tag, "_resp"},  {62'd0, mem_axi.bvalid, mem_axi.rvalid}, 64'd0);
    chk({tag, "_rdata"}, {32'd0, mem_axi.rdata}, 64'd0);
    chk({tag, "_sram"},  {13'd0, sram_en, sram_we, sram_addr, sram_wdata}, 64'd0);
    chk({tag, "_out"},   {55'd0, out_valid, out_data}, 64'd0);
    chk({tag, "_err"},   {31'd0, err, err_addr}, 64'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] d;
    int n;

    n_en = 0; n_out = 0; out_byte = 8'd0; sram_rdata = 32'd0;
    mem_axi.awvalid = 1'b0; mem_axi.awaddr = 32'd0; mem_axi.awprot = 3'd0;
    mem_axi.wvalid = 1'b0; mem_axi.wdata = 32'd0; mem_axi.wstrb = 4'd0;
    mem_axi.arvalid = 1'b0; mem_axi.araddr = 32'd0; mem_axi.arprot = 3'd0;
    mem_axi.bready = 1'b1; mem_axi.rready = 1'b1;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    resetn = 1'b1;
    tick(); tick();
    evt.delete(); rlog.delete();

    // Tie from reset: write wins, then a second tie while the write is in service goes to the read.
    chk("tie_ready", {61'd0, mem_axi.awready, mem_axi.wready, mem_axi.arready}, 64'd7);
    mem_axi.awaddr = 32'h300; mem_axi.wdata = 32'hCAFE_F00D; mem_axi.wstrb = 4'hF;
    mem_axi.araddr = 32'h300;
    mem_axi.awvalid = 1'b1; mem_axi.wvalid = 1'b1; mem_axi.arvalid = 1'b1;
    tick();
    mem_axi.awvalid = 1'b0; mem_axi.wvalid = 1'b0; mem_axi.arvalid = 1'b0;
    send_w(32'h304, 32'h0BAD_BEEF, 4'hF);
    n = 0;
    while (evt.size() < 3 && n < BUDGET) begin tick(); n++; end
    chk("tie_count", 64'(evt.size()), 64'd3);
    if (evt.size() >= 3) begin
      chk("tie_order0", 64'(evt[0]), 64'd0);
      chk("tie_order1", 64'(evt[1]), 64'd1);
      chk("tie_order2", 64'(evt[2]), 64'd0);
    end
    if (rlog.size() >= 1) chk("tie_rdata", {32'd0, rlog[0]}, 64'hCAFE_F00D);
    tick(); tick();

    // Basic write then read with idle latencies.
    send_w(32'h100, 32'h1234, 4'hF);
    wait_b(lat);
    chk("wr_lat", 64'(lat), 64'd2);
    tick(); tick();
    send_ar(32'h100);
    wait_r(lat, d);
    chk("rd_lat", 64'(lat), 64'd3);
    chk("rd_data", {32'd0, d}, 64'h1234);
    tick(); tick();
    send_ar(32'h304);
    wait_r(lat, d);
    chk("rd_second_tie_wr", {32'd0, d}, 64'h0BAD_BEEF);
    tick(); tick();

    // Byte strobe merge.
    send_w(32'h200, 32'h1111_1111, 4'hF);
    wait_b(lat); tick();
    send_w(32'h200, 32'hAABB_CCDD, 4'b0010);
    wait_b(lat); tick();
    send_ar(32'h200);
    wait_r(lat, d);
    chk("strb_merge", {32'd0, d}, 64'h1111_CC11);
    tick(); tick();

    // MMIO character output.
    n_en = 0; n_out = 0;
    send_w(32'h1000_0000, 32'h41, 4'hF);
    wait_b(lat);
    chk("mmio_lat", 64'(lat), 64'd2);
    tick(); tick();
    chk("mmio_pulses", 64'(n_out), 64'd1);
    chk("mmio_byte", {56'd0, out_byte}, 64'h41);
    chk("mmio_no_sram", 64'(n_en), 64'd0);
    chk("mmio_no_err", {63'd0, err}, 64'd0);

    // Out-of-bounds read, then a second OOB write that must not move err_addr.
    n_en = 0;
    send_ar(32'h0002_0000);
    wait_r(lat, d);
    chk("oob_rd_lat", 64'(lat), 64'd3);
    chk("oob_rdata", {32'd0, d}, 64'd0);
    tick();
    chk("oob_err", {31'd0, err, err_addr}, {31'd0, 1'b1, 32'h0002_0000});
    send_w(32'h0003_0000, 32'hFFFF_FFFF, 4'hF);
    wait_b(lat); tick(); tick();
    chk("oob_err_keep", {31'd0, err, err_addr}, {31'd0, 1'b1, 32'h0002_0000});
    chk("oob_no_sram", 64'(n_en), 64'd0);

    // Stalled read response, then reset while in RD_RESP.
    mem_axi.rready = 1'b0;
    send_ar(32'h100);
    wait_r(lat, d);
    chk("stall_data", {32'd0, d}, 64'h1234);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {31'd0, mem_axi.rvalid, mem_axi.rdata}, {31'd0, 1'b1, 32'h1234});
    end
    #1 resetn = 1'b0;
    #1;
    chk_reset("midrst");
    #1 resetn = 1'b1;
    mem_axi.rready = 1'b1;
    tick(); tick();
    evt.delete(); rlog.delete();
    tick(); tick();
    chk("midrst_no_resp", 64'(evt.size()), 64'd0);
    send_ar(32'h100);
    wait_r(lat, d);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_data", {32'd0, d}, 64'h1234);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
